tag_verify: RTL
===============

TAG_VERIFY -- requirements
Module: tag_verify

Interface
REQ-001 SHALL have parameter y, 40, plaintext width in bits; must match the decryption core's plaintext width.
REQ-002 SHALL have parameter CW, 32, tag compare chunk width; must divide 128.
REQ-003 SHALL have parameter TIMEOUT, 255, maximum WAIT cycles before abort (1..65535).
REQ-004 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-005 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-006 SHALL have port start  input  1  one-cycle pulse arming the block; issued alongside decryption_start.
REQ-007 SHALL have port expected_tag  input  128  received tag; sampled on accepted start.
REQ-008 SHALL have port decryption_ready  input  1  done flag from the decryption core (majority-voted).
REQ-009 SHALL have port plain_text  input  y  decrypted text from the decryption core.
REQ-010 SHALL have port tag  input  128  computed tag from the decryption core.
REQ-011 SHALL have port out_ready  input  1  consumer accepts pt_out.
REQ-012 SHALL have port pt_out  output  y  released plaintext; zero unless pt_valid.
REQ-013 SHALL have port pt_valid  output  1  pt_out valid, authenticated.
REQ-014 SHALL have port auth_fail  output  1  one-cycle pulse: tag mismatch.
REQ-015 SHALL have port timeout  output  1  one-cycle pulse: WAIT exceeded TIMEOUT.
REQ-016 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-017 SHALL implement FSM states IDLE, WAIT, COMPARE, RELEASE, FAIL.
REQ-018 IDLE: start=1 SHALL latch expected_tag, clear wait counter, go to WAIT; start in any other state SHALL be ignored.
REQ-019 WAIT: decryption_ready=1 SHALL latch plain_text and tag into internal registers, clear the diff accumulator and chunk index, and go to COMPARE.
REQ-020 WAIT: the 16-bit wait counter SHALL increment each cycle without ready; reaching TIMEOUT SHALL pulse timeout for 1 cycle and return to IDLE.
REQ-021 COMPARE: SHALL OR-accumulate the XOR of one CW-bit chunk of latched tag vs expected_tag per cycle, LSB chunk first, for exactly 128/CW cycles, with no early exit (constant time).
REQ-022 After the last chunk: diff==0 SHALL go to RELEASE, otherwise FAIL.
REQ-023 RELEASE: pt_valid=1 and pt_out=latched plaintext, held stable until out_ready=1; on that cycle's edge, go to IDLE.
REQ-024 FAIL: auth_fail=1 for exactly one cycle, pt_out=0, then IDLE; latched plaintext and tag SHALL be cleared to zero on entering FAIL.
REQ-025 Latency, CW=32: first cycle with decryption_ready high = cycle N; pt_valid or auth_fail SHALL first be high in cycle N+5.
REQ-026 decryption_ready dropping or changing data after capture SHALL have no effect.
REQ-027 auth_fail and timeout SHALL never be high in the same cycle; neither SHALL coincide with pt_valid.

Reset
REQ-028 rst=1 SHALL asynchronously force IDLE and clear all registers.
REQ-029 During and after reset until the next release, outputs SHALL be: pt_out=0, pt_valid=0, auth_fail=0, timeout=0, busy=0.
REQ-030 Reset asserted mid-COMPARE or mid-RELEASE SHALL abort with no pulse on auth_fail or timeout.

Structure
REQ-031 State encoding and the CHUNKS=128/CW constant SHALL reside in shared package tag_verify_pkg.
REQ-032 The per-chunk XOR/OR-reduce datapath SHALL be the single sub-module tag_chunk_cmp; FSM and counters SHALL stay in tag_verify.

Verification
REQ-033 Match: start with expected_tag=128'h0123...CDEF; ready at cycle 10 with tag equal, plain_text=40'hA5A5A5A5A5, out_ready=1 -> pt_valid in cycle 15, pt_out=40'hA5A5A5A5A5, then IDLE.
REQ-034 Single-bit mismatch in tag bit 127 -> auth_fail pulse in cycle N+5, pt_out=0, pt_valid never high; bit 0 mismatch -> identical timing.
REQ-035 Backpressure: out_ready=0 for 7 cycles after pt_valid -> pt_valid and pt_out held stable 8 cycles, release on the first out_ready=1 cycle.
REQ-036 Timeout: TIMEOUT=20, no decryption_ready -> timeout pulse exactly 20 cycles after WAIT entry, busy low the next cycle.
REQ-037 Second start while in COMPARE with a different expected_tag -> ignored; result uses the first expected_tag.
REQ-038 rst asserted at COMPARE chunk 2 -> all outputs 0 immediately; no auth_fail or timeout pulse; a fresh start then behaves as in REQ-033.

Source files
------------

// File: rtl/tag_verify_pkg.sv
// Shared state encoding and tag/chunk geometry for the tag verifier.
package tag_verify_pkg;

   localparam int TAG_W      = 128;
   localparam int CW_DEFAULT = 32;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT,
      ST_COMPARE,
      ST_RELEASE,
      ST_FAIL
   } state_t;

   function automatic int chunks_for(input int cw);
      return TAG_W / cw;
   endfunction

   localparam int CHUNKS = chunks_for(CW_DEFAULT);

endpackage

// File: rtl/tag_verify_chunk_cmp.sv
// One CW-bit slice of the tag XOR, OR-folded into the running difference.
module tag_chunk_cmp
   import tag_verify_pkg::*;
#(
   parameter int CW   = CW_DEFAULT,
   parameter int NCH  = CHUNKS,
   parameter int IDXW = 2
) (
   input  logic [TAG_W-1:0] tag_i,
   input  logic [TAG_W-1:0] exp_i,
   input  logic [IDXW-1:0]  idx_i,
   input  logic [CW-1:0]    diff_i,
   output logic [CW-1:0]    diff_o
);

   logic [CW-1:0] xor_chunk [NCH];

   for (genvar g = 0; g < NCH; g++) begin : g_chunk
      assign xor_chunk[g] = tag_i[g*CW +: CW] ^ exp_i[g*CW +: CW];
   end

   assign diff_o = diff_i | xor_chunk[idx_i];

endmodule

// File: rtl/tag_verify.sv
// Holds decrypted plaintext until its tag is checked in constant time; releases it or signals failure/timeout.
module tag_verify
   import tag_verify_pkg::*;
#(
   parameter int y       = 40,
   parameter int CW      = CW_DEFAULT,
   parameter int TIMEOUT = 255
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [TAG_W-1:0] expected_tag,
   input  logic             decryption_ready,
   input  logic [y-1:0]     plain_text,
   input  logic [TAG_W-1:0] tag,
   input  logic             out_ready,
   output logic [y-1:0]     pt_out,
   output logic             pt_valid,
   output logic             auth_fail,
   output logic             timeout,
   output logic             busy
);

   localparam int             NCH      = chunks_for(CW);
   localparam int             IDXW     = (NCH > 1) ? $clog2(NCH) : 1;
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCH - 1);
   localparam logic [15:0]    TO_CNT   = 16'(TIMEOUT);

   state_t           state_q, state_d;
   logic [15:0]      cnt_q, cnt_d;
   logic [TAG_W-1:0] exp_q, exp_d;
   logic [TAG_W-1:0] tag_q, tag_d;
   logic [y-1:0]     pt_q, pt_d;
   logic [CW-1:0]    diff_q, diff_d;
   logic [IDXW-1:0]  idx_q, idx_d;
   logic [CW-1:0]    diff_nxt;

   tag_chunk_cmp #(
      .CW   (CW),
      .NCH  (NCH),
      .IDXW (IDXW)
   ) u_cmp (
      .tag_i  (tag_q),
      .exp_i  (exp_q),
      .idx_i  (idx_q),
      .diff_i (diff_q),
      .diff_o (diff_nxt)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         exp_q   <= '0;
         tag_q   <= '0;
         pt_q    <= '0;
         diff_q  <= '0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         exp_q   <= exp_d;
         tag_q   <= tag_d;
         pt_q    <= pt_d;
         diff_q  <= diff_d;
         idx_q   <= idx_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      exp_d   = exp_q;
      tag_d   = tag_q;
      pt_d    = pt_q;
      diff_d  = diff_q;
      idx_d   = idx_q;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               exp_d   = expected_tag;
               cnt_d   = '0;
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (decryption_ready) begin
               pt_d    = plain_text;
               tag_d   = tag;
               diff_d  = '0;
               idx_d   = '0;
               state_d = ST_COMPARE;
            end else if (cnt_q == TO_CNT) begin
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         ST_COMPARE: begin
            // Every chunk is visited regardless of earlier differences.
            diff_d = diff_nxt;
            idx_d  = idx_q + IDXW'(1);
            if (idx_q == LAST_IDX) begin
               if (diff_nxt != '0) begin
                  pt_d    = '0;
                  tag_d   = '0;
                  state_d = ST_FAIL;
               end else begin
                  state_d = ST_RELEASE;
               end
            end
         end
         ST_RELEASE: begin
            if (out_ready) state_d = ST_IDLE;
         end
         ST_FAIL: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   assign busy      = (state_q != ST_IDLE);
   assign pt_valid  = (state_q == ST_RELEASE);
   assign pt_out    = pt_valid ? pt_q : '0;
   assign auth_fail = (state_q == ST_FAIL);
   assign timeout   = (state_q == ST_WAIT) && !decryption_ready && (cnt_q == TO_CNT);

endmodule
